// File: rtl/pcm_cpu_arbiter.sv
// Round-robin arbiter that funnels four CPU request ports into one PCM_MM_reg
// transaction at a time, with a timeout guarding against a silent downstream.
module pcm_cpu_arbiter #(
    parameter int unsigned NCPU    = 4,
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(16'hDEAD)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCPU-1:0]          cpu_req,
    input  logic [NCPU-1:0]          cpu_write,
    input  logic [NCPU*ADDR_W-1:0]   cpu_addr,
    input  logic [NCPU*DATA_W-1:0]   cpu_data_in,
    output logic [NCPU-1:0]          cpu_ready,
    output logic [NCPU-1:0]          cpu_err,
    output logic [NCPU*DATA_W-1:0]   cpu_data_out,
    output logic                     mm_init,
    output logic [ADDR_W-1:0]        mm_addr,
    output logic [DATA_W-1:0]        mm_data,
    output logic                     mm_write,
    input  logic                     mm_ready,
    input  logic [DATA_W-1:0]        mm_rdata,
    output logic                     busy
);

    localparam int unsigned PTR_W = $clog2(NCPU);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_n;
    logic [PTR_W-1:0]    grant, grant_n;
    logic [PTR_W-1:0]    ptr, ptr_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                mm_init_n, mm_write_n, busy_n;
    logic [ADDR_W-1:0]   mm_addr_n;
    logic [DATA_W-1:0]   mm_data_n;
    logic [NCPU-1:0]     ready_n, err_n;
    logic [NCPU*DATA_W-1:0] dout_n;
    logic                found;
    logic [PTR_W-1:0]    pick, cand;

    // First requester at or above the round-robin pointer, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NCPU; i++) begin
            cand = PTR_W'((32'(ptr) + i) % NCPU);
            if (!found && cpu_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        ptr_n      = ptr;
        cnt_n      = cnt;
        mm_init_n  = 1'b0;
        mm_addr_n  = mm_addr;
        mm_data_n  = mm_data;
        mm_write_n = mm_write;
        ready_n    = '0;
        err_n      = '0;
        dout_n     = cpu_data_out;

        case (state)
            IDLE: begin
                if (found) begin
                    grant_n    = pick;
                    mm_addr_n  = cpu_addr[int'(pick)*ADDR_W +: ADDR_W];
                    mm_data_n  = cpu_data_in[int'(pick)*DATA_W +: DATA_W];
                    mm_write_n = cpu_write[pick];
                    mm_init_n  = 1'b1;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // A completion in the expiry cycle still counts as a success
                if (mm_ready) begin
                    dout_n[int'(grant)*DATA_W +: DATA_W] = mm_rdata;
                    ready_n[grant] = 1'b1;
                    state_n        = RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    dout_n[int'(grant)*DATA_W +: DATA_W] = ERR_DATA;
                    ready_n[grant] = 1'b1;
                    err_n[grant]   = 1'b1;
                    state_n        = RESP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                ptr_n   = (grant == PTR_W'(NCPU - 1)) ? '0 : grant + PTR_W'(1);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= '0;
            ptr          <= '0;
            cnt          <= '0;
            mm_init      <= 1'b0;
            mm_addr      <= '0;
            mm_data      <= '0;
            mm_write     <= 1'b0;
            cpu_ready    <= '0;
            cpu_err      <= '0;
            cpu_data_out <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            ptr          <= ptr_n;
            cnt          <= cnt_n;
            mm_init      <= mm_init_n;
            mm_addr      <= mm_addr_n;
            mm_data      <= mm_data_n;
            mm_write     <= mm_write_n;
            cpu_ready    <= ready_n;
            cpu_err      <= err_n;
            cpu_data_out <= dout_n;
            busy         <= busy_n;
        end
    end

endmodule
